// File: rtl/lc3_pkg.sv
// ============================================================================
// lc3_pkg: shared LC-3 constants and branch FSM state type.  Rev 1.0
// ============================================================================
`default_nettype none

package lc3_pkg;

   localparam int         WORD_W = 16;
   localparam logic [3:0] OP_BR  = 4'b0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EVAL    = 2'd1,
      RESOLVE = 2'd2
   } branch_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter: WORD_W-bit up counter that sticks at all-ones.  Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter
   import lc3_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   output logic [WORD_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {WORD_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/branch_unit.sv
// ============================================================================
// branch_unit: resolves LC-3 BR against snapshotted N/Z/P in two cycles.
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_unit
   import lc3_pkg::*;
#(
   parameter int OFFSET_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] IR,
   input  logic [WORD_W-1:0] PC,
   input  logic              N,
   input  logic              Z,
   input  logic              P,
   output logic              busy,
   output logic              done,
   output logic              BEN,
   output logic              ld_pc,
   output logic [WORD_W-1:0] pc_target,
   output logic              illegal,
   output logic [WORD_W-1:0] branch_count,
   output logic [WORD_W-1:0] taken_count
);

   branch_state_t     r_state;
   logic [WORD_W-1:0] r_ir;
   logic [WORD_W-1:0] r_pc;
   logic [2:0]        r_nzp;

   logic              w_legal;
   logic              w_ben;
   logic [WORD_W-1:0] w_offset;
   logic [WORD_W-1:0] w_target;
   logic              w_branch_inc;
   logic              w_taken_inc;

   assign w_legal  = (r_ir[15:12] == OP_BR);
   assign w_ben    = w_legal & (|(r_ir[11:9] & r_nzp));
   assign w_offset = {{(WORD_W-OFFSET_W){r_ir[OFFSET_W-1]}}, r_ir[OFFSET_W-1:0]};
   assign w_target = r_pc + w_offset;

   // Statistics advance on the RESOLVE->IDLE edge from the registered results.
   assign w_branch_inc = (r_state == RESOLVE) & ~illegal;
   assign w_taken_inc  = (r_state == RESOLVE) & ld_pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ir      <= '0;
         r_pc      <= '0;
         r_nzp     <= 3'b000;
         busy      <= 1'b0;
         done      <= 1'b0;
         BEN       <= 1'b0;
         ld_pc     <= 1'b0;
         illegal   <= 1'b0;
         pc_target <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               done    <= 1'b0;
               ld_pc   <= 1'b0;
               illegal <= 1'b0;
               if (start) begin
                  r_ir    <= IR;
                  r_pc    <= PC;
                  r_nzp   <= {N, Z, P};
                  busy    <= 1'b1;
                  r_state <= EVAL;
               end
            end
            EVAL: begin
               BEN       <= w_ben;
               ld_pc     <= w_ben;
               illegal   <= ~w_legal;
               done      <= 1'b1;
               pc_target <= w_target;
               r_state   <= RESOLVE;
            end
            RESOLVE: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               ld_pc   <= 1'b0;
               illegal <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               ld_pc   <= 1'b0;
               illegal <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   sat_counter u_branch_count (
      .clk   (clk),
      .reset (reset),
      .inc   (w_branch_inc),
      .count (branch_count)
   );

   sat_counter u_taken_count (
      .clk   (clk),
      .reset (reset),
      .inc   (w_taken_inc),
      .count (taken_count)
   );

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
// ============================================================================
// tb_branch_unit: directed and random checks of branch_unit against a model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] IR;
   logic [15:0] PC;
   logic        N, Z, P;
   logic        busy, done, BEN, ld_pc, illegal;
   logic [15:0] pc_target, branch_count, taken_count;

   logic        sc_inc;
   logic [15:0] sc_count;

   int checks   = 0;
   int failures = 0;
   int m_branches = 0;
   int m_taken    = 0;
   bit m_ben      = 1'b0;
   int m_target   = 0;

   always #5 clk = ~clk;

   branch_unit #(.OFFSET_W(9)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .IR           (IR),
      .PC           (PC),
      .N            (N),
      .Z            (Z),
      .P            (P),
      .busy         (busy),
      .done         (done),
      .BEN          (BEN),
      .ld_pc        (ld_pc),
      .pc_target    (pc_target),
      .illegal      (illegal),
      .branch_count (branch_count),
      .taken_count  (taken_count)
   );

   sat_counter sc (
      .clk   (clk),
      .reset (reset),
      .inc   (sc_inc),
      .count (sc_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // Reference: branch taken iff BR opcode and any selected flag is set.
   function automatic bit ref_taken(input logic [15:0] ir, input logic [2:0] nzp);
      if (ir[15:12] != 4'd0) return 1'b0;
      return (ir[11] && nzp[2]) || (ir[10] && nzp[1]) || (ir[9] && nzp[0]);
   endfunction

   function automatic int ref_target(input logic [15:0] ir, input logic [15:0] pc);
      int off;
      off = int'(ir[8:0]);
      if (off > 255) off = off - 512;
      return (int'(pc) + off + 65536) % 65536;
   endfunction

   task automatic run_br(input logic [15:0] ir, input logic [15:0] pc, input logic [2:0] nzp,
                         input bit chg, input logic [2:0] nzp2, input string tag);
      bit legal;
      @(negedge clk);
      IR = ir; PC = pc; {N, Z, P} = nzp; start = 1'b1;
      @(posedge clk); #1;
      check({tag, ".busy_eval"}, busy, 1);
      check({tag, ".done_eval"}, done, 0);
      start = 1'b0;
      IR = 16'($urandom);
      PC = 16'($urandom);
      if (chg) {N, Z, P} = nzp2;
      legal    = (ir[15:12] == 4'd0);
      m_ben    = ref_taken(ir, nzp);
      m_target = ref_target(ir, pc);
      @(posedge clk); #1;
      check({tag, ".done"},      done, 1);
      check({tag, ".busy"},      busy, 1);
      check({tag, ".BEN"},       BEN, m_ben);
      check({tag, ".ld_pc"},     ld_pc, m_ben);
      check({tag, ".illegal"},   illegal, !legal);
      check({tag, ".pc_target"}, pc_target, m_target);
      if (legal) m_branches = sat(m_branches + 1);
      if (m_ben) m_taken = sat(m_taken + 1);
      @(posedge clk); #1;
      check({tag, ".done_idle"},    done, 0);
      check({tag, ".busy_idle"},    busy, 0);
      check({tag, ".ld_pc_idle"},   ld_pc, 0);
      check({tag, ".BEN_hold"},     BEN, m_ben);
      check({tag, ".target_hold"},  pc_target, m_target);
      check({tag, ".branch_count"}, branch_count, m_branches);
      check({tag, ".taken_count"},  taken_count, m_taken);
   endtask

   initial begin
      int ndone;
      logic [15:0] rir;
      reset = 1'b1; start = 1'b0; IR = '0; PC = '0; N = 0; Z = 0; P = 0; sc_inc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.busy", busy, 0);
      check("reset.done", done, 0);
      check("reset.BEN", BEN, 0);
      check("reset.ld_pc", ld_pc, 0);
      check("reset.illegal", illegal, 0);
      check("reset.pc_target", pc_target, 0);
      check("reset.branch_count", branch_count, 0);
      check("reset.taken_count", taken_count, 0);
      @(negedge clk); reset = 1'b0;

      // Flags all clear right after reset: never taken even with mask 111.
      run_br(16'h0E00, 16'h1234, 3'b000, 0, 3'b000, "flags_clear");
      run_br(16'h0405, 16'h3001, 3'b010, 0, 3'b000, "taken_fwd");
      check("taken_fwd.target_const", pc_target, 16'h3006);
      run_br(16'h09FE, 16'h3010, 3'b001, 0, 3'b000, "not_taken_back");
      check("not_taken_back.target_const", pc_target, 16'h300E);
      run_br(16'h0E01, 16'hFFFF, 3'b100, 1, 3'b001, "wrap_snapshot");
      check("wrap_snapshot.target_const", pc_target, 16'h0000);
      run_br(16'h0FFF, 16'h0000, 3'b010, 0, 3'b000, "wrap_down");
      run_br(16'h1E01, 16'h4000, 3'b111, 0, 3'b000, "illegal");
      run_br(16'h0100, 16'h4000, 3'b000, 1, 3'b111, "snapshot_zero");
      run_br(16'h0000, 16'h5555, 3'b111, 0, 3'b000, "mask_zero");

      // start held for six edges: accepted at k and k+3 only.
      @(negedge clk);
      IR = 16'h0E10; PC = 16'h2000; {N, Z, P} = 3'b010; start = 1'b1;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("busy_hold.done", done, (i == 1 || i == 4) ? 1 : 0);
         check("busy_hold.ld_pc", ld_pc, (i == 1 || i == 4) ? 1 : 0);
         if (done) ndone++;
      end
      @(negedge clk); start = 1'b0;
      check("busy_hold.count", ndone, 2);
      m_branches = sat(m_branches + 2);
      m_taken    = sat(m_taken + 2);
      repeat (3) @(posedge clk);
      #1;
      check("busy_hold.done_after", done, 0);
      check("busy_hold.branch_count", branch_count, m_branches);
      check("busy_hold.taken_count", taken_count, m_taken);

      // Reset while in EVAL aborts the branch.
      @(negedge clk);
      IR = 16'h0E05; PC = 16'h0100; {N, Z, P} = 3'b111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("abort.busy_eval", busy, 1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      check("abort.ld_pc", ld_pc, 0);
      check("abort.branch_count", branch_count, 0);
      check("abort.taken_count", taken_count, 0);
      @(posedge clk); #1;
      check("abort.done_next", done, 0);
      check("abort.ld_pc_next", ld_pc, 0);
      m_branches = 0; m_taken = 0;

      // Reset has priority over a simultaneous start.
      @(negedge clk); reset = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      check("reset_prio.busy", busy, 0);
      @(negedge clk); reset = 1'b0; start = 1'b0;

      for (int t = 0; t < 300; t++) begin
         rir = 16'($urandom);
         if ($urandom_range(0, 9) < 8) rir[15:12] = 4'd0;
         run_br(rir, 16'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), "rand");
      end

      // Saturation on a stand-alone counter instance.
      @(negedge clk); sc_inc = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      check("sat.below", sc_count, 16'hFFFE);
      repeat (3) @(posedge clk);
      #1;
      check("sat.hold", sc_count, sat(65537));
      @(negedge clk); sc_inc = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
